mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs: ALU result, rt data, rd, and the memory, register-write and write-back-select controls.
- Performs word loads and stores on a req/ack data bus with a multicycle, timeout-guarded FSM.
- Drives stall_o back to the EX/MEM register's active-high en (stall) input and to upstream stages.
- Presents load data and pass-through controls to the MEM/WB register.

Parameters:
- DATA_W, 32, data/address width (matches INSTR_WIDTH).
- TIMEOUT, 16, max cycles in BUSY waiting for dbus_ack_i before bus error; must be >=2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- mem_r_i  in  1  load request (EX/MEM mem_r).
- w_mem_ena_i  in  1  store request (EX/MEM w_mem_ena).
- alu_res_i  in  DATA_W  effective address / ALU result.
- rt_data_i  in  DATA_W  store data.
- rd_i  in  5  destination register.
- w_reg_ena_i  in  1  register write enable.
- wb_sel_i  in  1  write-back select (1 = memory data).
- stall_o  out  1  hold EX/MEM and earlier stages.
- dbus_req_o  out  1  bus request, registered.
- dbus_we_o  out  1  1 = write, registered.
- dbus_addr_o  out  DATA_W  bus address, registered.
- dbus_wdata_o  out  DATA_W  bus write data, registered.
- dbus_ack_i  in  1  bus completion strobe.
- dbus_rdata_i  in  DATA_W  read data, valid with ack.
- mem_rdata_o  out  DATA_W  captured load data, registered.
- alu_res_o  out  DATA_W  alu_res_i pass-through.
- rd_o  out  5  rd_i pass-through.
- wb_sel_o  out  1  wb_sel_i pass-through.
- w_reg_ena_o  out  1  gated register write enable.
- addr_err_o  out  1  misaligned-access pulse, combinational.
- bus_err_o  out  1  timeout pulse, registered.

Behaviour:
- Reset values:
  - State IDLE.
  - dbus_req_o=0, dbus_we_o=0, dbus_addr_o=0, dbus_wdata_o=0.
  - mem_rdata_o=0, bus_err_o=0, timeout counter=0.
  - With inputs low, stall_o=0 and addr_err_o=0.
- Definitions:
  - access = mem_r_i | w_mem_ena_i.
  - is_store = w_mem_ena_i; store wins if both requests are high.
  - aligned = (alu_res_i[1:0]==2'b00).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If access & aligned: stall_o=1 combinationally.
  - On that edge, latch addr={alu_res_i[DATA_W-1:2],2'b00}, wdata=rt_data_i, we=is_store; set dbus_req_o=1; clear counter; go BUSY.
  - If access & ~aligned: addr_err_o=1 that cycle, no bus activity, stall_o=0, stay IDLE.
  - Otherwise pass through with stall_o=0.
- BUSY:
  - stall_o=1; req/we/addr/wdata held stable.
  - Counter increments each cycle.
  - If dbus_ack_i is sampled high: capture mem_rdata_o<=dbus_rdata_i (loads only; stores leave it unchanged); dbus_req_o<=0; go DONE.
  - Else if counter==TIMEOUT-1: dbus_req_o<=0; mem_rdata_o<=0; bus_err_o<=1 for one cycle; go DONE.
  - Ack takes priority over timeout in the same cycle.
- DONE:
  - stall_o=0 and mem_rdata_o is valid; EX/MEM advances at this edge; next state IDLE.
  - A new access seen in IDLE on the following cycle starts normally.
  - Minimum access latency: 3 cycles, with ack in the first BUSY cycle.
- dbus_ack_i outside BUSY is ignored.
- w_reg_ena_o = w_reg_ena_i & ~stall_o & ~(mem_r_i & ~is_store & ~aligned).
- alu_res_o, rd_o, wb_sel_o are combinational pass-throughs.
- Reset mid-operation (any state): next edge returns to IDLE, dbus_req_o=0, bus_err_o=0, counter=0; a late ack is ignored.
- Back-to-back accesses: each costs IDLE->BUSY->DONE with no overlap; one outstanding request max.

Test Plan:
- Reset then idle, inputs 0 -> stall_o=0, dbus_req_o=0, mem_rdata_o=0, w_reg_ena_o follows w_reg_ena_i.
- Load addr 0x0000_0010, ack with rdata 0xDEADBEEF two cycles after req rises:
  - stall_o high 3 cycles, dbus_we_o=0, dbus_addr_o=0x10.
  - mem_rdata_o=0xDEADBEEF in DONE, w_reg_ena_o=1 only in DONE.
- Store addr 0x20, data 0x12345678, ack first BUSY cycle -> dbus_we_o=1, dbus_wdata_o=0x12345678, stall_o high exactly 2 cycles, mem_rdata_o unchanged.
- Load addr 0x13 -> addr_err_o=1 same cycle, dbus_req_o stays 0, stall_o=0, w_reg_ena_o=0.
- Load with no ack, TIMEOUT=16 -> req high 16 cycles, then bus_err_o pulses 1 cycle, mem_rdata_o=0, stall_o released in DONE.
- rst asserted in the 3rd BUSY cycle, then ack one cycle later -> dbus_req_o=0 after the edge, state IDLE, ack ignored, mem_rdata_o=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   MEM-stage load/store engine. Takes the EX/MEM register outputs, performs
//   one word access at a time on a req/ack data bus and holds the upstream
//   pipeline (stall_o) until the access completes or times out.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   mem_r_i           load request
//   w_mem_ena_i       store request (wins when both requests are high)
//   alu_res_i         effective address / ALU result
//   rt_data_i         store data
//   rd_i              destination register
//   w_reg_ena_i       register write enable
//   wb_sel_i          write-back select (1 = memory data)
//   stall_o           hold EX/MEM and earlier stages
//   dbus_req_o        bus request (registered)
//   dbus_we_o         bus write enable (registered)
//   dbus_addr_o       word-aligned bus address (registered)
//   dbus_wdata_o      bus write data (registered)
//   dbus_ack_i        bus completion strobe
//   dbus_rdata_i      bus read data, valid with ack
//   mem_rdata_o       captured load data (registered)
//   alu_res_o         alu_res_i pass-through
//   rd_o              rd_i pass-through
//   wb_sel_o          wb_sel_i pass-through
//   w_reg_ena_o       register write enable, gated by stall / misaligned load
//   addr_err_o        misaligned-access pulse (combinational)
//   bus_err_o         bus timeout pulse (registered)
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_r_i,
   input  logic              w_mem_ena_i,
   input  logic [DATA_W-1:0] alu_res_i,
   input  logic [DATA_W-1:0] rt_data_i,
   input  logic [4:0]        rd_i,
   input  logic              w_reg_ena_i,
   input  logic              wb_sel_i,
   output logic              stall_o,
   output logic              dbus_req_o,
   output logic              dbus_we_o,
   output logic [DATA_W-1:0] dbus_addr_o,
   output logic [DATA_W-1:0] dbus_wdata_o,
   input  logic              dbus_ack_i,
   input  logic [DATA_W-1:0] dbus_rdata_i,
   output logic [DATA_W-1:0] mem_rdata_o,
   output logic [DATA_W-1:0] alu_res_o,
   output logic [4:0]        rd_o,
   output logic              wb_sel_o,
   output logic              w_reg_ena_o,
   output logic              addr_err_o,
   output logic              bus_err_o
);

   localparam int                CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;

   logic access;
   logic is_store;
   logic aligned;
   logic start;
   logic ack_hit;
   logic timeout_hit;

   assign access   = mem_r_i | w_mem_ena_i;
   assign is_store = w_mem_ena_i;
   assign aligned  = (alu_res_i[1:0] == 2'b00);

   // Next-state and combinational outputs
   always_comb begin
      state_nxt   = state;
      stall_o     = 1'b0;
      addr_err_o  = 1'b0;
      start       = 1'b0;
      ack_hit     = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (access) begin
               if (aligned) begin
                  stall_o   = 1'b1;
                  start     = 1'b1;
                  state_nxt = BUSY;
               end else begin
                  addr_err_o = 1'b1;
               end
            end
         end
         BUSY: begin
            stall_o = 1'b1;
            // Ack has priority over a timeout landing in the same cycle
            if (dbus_ack_i) begin
               ack_hit   = 1'b1;
               state_nxt = DONE;
            end else if (cnt == CNT_LAST) begin
               timeout_hit = 1'b1;
               state_nxt   = DONE;
            end
         end
         DONE: begin
            // stall drops here so EX/MEM advances at the end of this cycle
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Bus request, counter and load-data registers
   always_ff @(posedge clk) begin
      if (rst) begin
         dbus_req_o   <= 1'b0;
         dbus_we_o    <= 1'b0;
         dbus_addr_o  <= '0;
         dbus_wdata_o <= '0;
         mem_rdata_o  <= '0;
         bus_err_o    <= 1'b0;
         cnt          <= '0;
      end else begin
         bus_err_o <= timeout_hit;
         if (start) begin
            dbus_req_o   <= 1'b1;
            dbus_we_o    <= is_store;
            dbus_addr_o  <= {alu_res_i[DATA_W-1:2], 2'b00};
            dbus_wdata_o <= rt_data_i;
            cnt          <= '0;
         end
         if (state == BUSY) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (ack_hit) begin
            dbus_req_o <= 1'b0;
            // Stores leave the last load data untouched
            if (!dbus_we_o) begin
               mem_rdata_o <= dbus_rdata_i;
            end
         end
         if (timeout_hit) begin
            dbus_req_o  <= 1'b0;
            mem_rdata_o <= '0;
         end
      end
   end

   assign alu_res_o = alu_res_i;
   assign rd_o      = rd_i;
   assign wb_sel_o  = wb_sel_i;

   // A misaligned load must not write back; a misaligned store has no
   // register write to suppress beyond what w_reg_ena_i already says.
   assign w_reg_ena_o = w_reg_ena_i & ~stall_o & ~(mem_r_i & ~is_store & ~aligned);

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_r_i;
   logic        w_mem_ena_i;
   logic [31:0] alu_res_i;
   logic [31:0] rt_data_i;
   logic [4:0]  rd_i;
   logic        w_reg_ena_i;
   logic        wb_sel_i;
   logic        stall_o;
   logic        dbus_req_o;
   logic        dbus_we_o;
   logic [31:0] dbus_addr_o;
   logic [31:0] dbus_wdata_o;
   logic        dbus_ack_i;
   logic [31:0] dbus_rdata_i;
   logic [31:0] mem_rdata_o;
   logic [31:0] alu_res_o;
   logic [4:0]  rd_o;
   logic        wb_sel_o;
   logic        w_reg_ena_o;
   logic        addr_err_o;
   logic        bus_err_o;

   int n_vec  = 0;
   int n_fail = 0;

   mem_access_unit #(.DATA_W(32), .TIMEOUT(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_r_i      (mem_r_i),
      .w_mem_ena_i  (w_mem_ena_i),
      .alu_res_i    (alu_res_i),
      .rt_data_i    (rt_data_i),
      .rd_i         (rd_i),
      .w_reg_ena_i  (w_reg_ena_i),
      .wb_sel_i     (wb_sel_i),
      .stall_o      (stall_o),
      .dbus_req_o   (dbus_req_o),
      .dbus_we_o    (dbus_we_o),
      .dbus_addr_o  (dbus_addr_o),
      .dbus_wdata_o (dbus_wdata_o),
      .dbus_ack_i   (dbus_ack_i),
      .dbus_rdata_i (dbus_rdata_i),
      .mem_rdata_o  (mem_rdata_o),
      .alu_res_o    (alu_res_o),
      .rd_o         (rd_o),
      .wb_sel_o     (wb_sel_o),
      .w_reg_ena_o  (w_reg_ena_o),
      .addr_err_o   (addr_err_o),
      .bus_err_o    (bus_err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        mem_r;
      logic        w_mem;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic        wreg;
      logic        wbsel;
      logic        e_stall;
      logic        e_aerr;
      logic        e_wreg;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mem_r_i     = 1'b0;
      w_mem_ena_i = 1'b0;
      alu_res_i   = 32'h0;
      rt_data_i   = 32'h0;
      rd_i        = 5'd0;
      w_reg_ena_i = 1'b0;
      wb_sel_i    = 1'b0;
      dbus_ack_i  = 1'b0;
      dbus_rdata_i = 32'h0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[6];
      int   stall_cnt;
      int   req_cnt;

      vecs[0] = '{1'b0, 1'b0, 32'h0000_1234, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 5'd31, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_0013, 5'd7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 32'h0000_0022, 5'd9,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[4] = '{1'b1, 1'b1, 32'h0000_0031, 5'd1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_0002, 5'd2,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;

      // Reset state
      chk("rst_req",    dbus_req_o,   32'h0);
      chk("rst_we",     dbus_we_o,    32'h0);
      chk("rst_addr",   dbus_addr_o,  32'h0);
      chk("rst_wdata",  dbus_wdata_o, 32'h0);
      chk("rst_rdata",  mem_rdata_o,  32'h0);
      chk("rst_buserr", bus_err_o,    32'h0);
      chk("rst_stall",  stall_o,      32'h0);
      chk("rst_aerr",   addr_err_o,   32'h0);

      // Idle / misaligned vectors: none of these may start a bus access
      for (int i = 0; i < 6; i++) begin
         step();
         mem_r_i     = vecs[i].mem_r;
         w_mem_ena_i = vecs[i].w_mem;
         alu_res_i   = vecs[i].alu;
         rd_i        = vecs[i].rd;
         w_reg_ena_i = vecs[i].wreg;
         wb_sel_i    = vecs[i].wbsel;
         #1;
         chk($sformatf("v%0d_stall", i), stall_o,     vecs[i].e_stall);
         chk($sformatf("v%0d_aerr",  i), addr_err_o,  vecs[i].e_aerr);
         chk($sformatf("v%0d_wreg",  i), w_reg_ena_o, vecs[i].e_wreg);
         chk($sformatf("v%0d_alu",   i), alu_res_o,   vecs[i].alu);
         chk($sformatf("v%0d_rd",    i), rd_o,        vecs[i].rd);
         chk($sformatf("v%0d_wbsel", i), wb_sel_o,    vecs[i].wbsel);
         step();
         chk($sformatf("v%0d_noreq", i), dbus_req_o,  32'h0);
         idle_inputs();
      end

      // Load 0x10, ack in the second BUSY cycle
      step();
      mem_r_i = 1'b1; alu_res_i = 32'h10; rd_i = 5'd5; w_reg_ena_i = 1'b1; wb_sel_i = 1'b1;
      #1;
      stall_cnt = 0;
      if (stall_o) stall_cnt++;
      chk("ld_wreg_idle", w_reg_ena_o, 32'h0);
      step();
      if (stall_o) stall_cnt++;
      chk("ld_req",  dbus_req_o,  32'h1);
      chk("ld_we",   dbus_we_o,   32'h0);
      chk("ld_addr", dbus_addr_o, 32'h10);
      chk("ld_wreg_busy", w_reg_ena_o, 32'h0);
      step();
      if (stall_o) stall_cnt++;
      dbus_ack_i = 1'b1; dbus_rdata_i = 32'hDEADBEEF;
      step();
      dbus_ack_i = 1'b0; dbus_rdata_i = 32'h0;
      #1;
      if (stall_o) stall_cnt++;
      chk("ld_stall_cycles", stall_cnt, 32'd3);
      chk("ld_rdata",   mem_rdata_o, 32'hDEADBEEF);
      chk("ld_wreg_done", w_reg_ena_o, 32'h1);
      chk("ld_req_off", dbus_req_o,  32'h0);
      idle_inputs();

      // Store 0x20 <- 0x12345678, ack in the first BUSY cycle
      step();
      w_mem_ena_i = 1'b1; alu_res_i = 32'h20; rt_data_i = 32'h12345678;
      #1;
      stall_cnt = 0;
      if (stall_o) stall_cnt++;
      step();
      if (stall_o) stall_cnt++;
      chk("st_we",    dbus_we_o,    32'h1);
      chk("st_wdata", dbus_wdata_o, 32'h12345678);
      chk("st_addr",  dbus_addr_o,  32'h20);
      dbus_ack_i = 1'b1; dbus_rdata_i = 32'hA5A5A5A5;
      step();
      dbus_ack_i = 1'b0;
      #1;
      if (stall_o) stall_cnt++;
      chk("st_stall_cycles", stall_cnt, 32'd2);
      chk("st_rdata_kept", mem_rdata_o, 32'hDEADBEEF);
      chk("st_req_off", dbus_req_o, 32'h0);
      idle_inputs();

      // Load 0x40 with no ack: timeout after 16 request cycles
      step();
      mem_r_i = 1'b1; alu_res_i = 32'h40;
      step();
      req_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (!dbus_req_o) break;
         req_cnt++;
         if (bus_err_o) chk("to_early_err", bus_err_o, 32'h0);
         step();
      end
      #1;
      chk("to_req_cycles", req_cnt,     32'd16);
      chk("to_buserr",     bus_err_o,   32'h1);
      chk("to_rdata",      mem_rdata_o, 32'h0);
      chk("to_stall",      stall_o,     32'h0);
      idle_inputs();
      step();
      chk("to_buserr_pulse", bus_err_o, 32'h0);

      // Load 0x44 with ack in first BUSY cycle, to make mem_rdata_o nonzero
      mem_r_i = 1'b1; alu_res_i = 32'h44;
      step();
      dbus_ack_i = 1'b1; dbus_rdata_i = 32'hCAFEF00D;
      step();
      chk("ld2_rdata", mem_rdata_o, 32'hCAFEF00D);
      idle_inputs();

      // Load 0x48, reset in the 3rd BUSY cycle, late ack afterwards
      step();
      mem_r_i = 1'b1; alu_res_i = 32'h48;
      step();
      step();
      step();
      chk("rs_busy_req", dbus_req_o, 32'h1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle_inputs();
      dbus_ack_i = 1'b1; dbus_rdata_i = 32'h55555555;
      #1;
      chk("rs_req",   dbus_req_o,  32'h0);
      chk("rs_stall", stall_o,     32'h0);
      chk("rs_rdata", mem_rdata_o, 32'h0);
      step();
      dbus_ack_i = 1'b0;
      chk("rs_late_ack_rdata", mem_rdata_o, 32'h0);
      chk("rs_late_ack_req",   dbus_req_o,  32'h0);
      chk("rs_buserr",         bus_err_o,   32'h0);

      // Fresh access after reset starts normally
      mem_r_i = 1'b1; alu_res_i = 32'h4C;
      #1;
      chk("post_rs_stall", stall_o, 32'h1);
      step();
      chk("post_rs_addr", dbus_addr_o, 32'h4C);
      dbus_ack_i = 1'b1; dbus_rdata_i = 32'h0BADF00D;
      step();
      chk("post_rs_rdata", mem_rdata_o, 32'h0BADF00D);
      idle_inputs();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
